mem_stream_initiator: RTL and testbench

MEM_STREAM_INITIATOR -- requirements
Module: mem_stream_initiator

---
 rtl/mem_stream_initiator.sv | 123 ++++++++++++
 tb/tb_mem_stream_initiator.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_initiator.sv
// mem_stream_initiator: streams num_words 8-byte reads or writes to a memory port,
// bounding reads in flight and folding read data into an XOR checksum.
module mem_stream_initiator #(
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter logic [31:0] SOURCE_ID       = 32'd0,
    parameter int unsigned TIMEOUT_CYCLES  = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op,
    input  logic [63:0] base_addr,
    input  logic [31:0] num_words,
    input  logic [63:0] wr_seed,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [63:0] checksum,
    output logic        spurious,
    input  logic        mem_init_done,
    output logic        mem_req_valid,
    output logic [63:0] mem_req_addr,
    output logic        mem_req_type,
    output logic [31:0] mem_req_source_id,
    output logic [63:0] mem_req_data,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_addr,
    input  logic [63:0] mem_resp_data,
    output logic        rd_valid,
    output logic [63:0] rd_addr,
    output logic [63:0] rd_data
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, WAIT_ACK = 3'd2, DRAIN = 3'd3, DONE = 3'd4, ERR = 3'd5;

    logic [2:0]    state_q, state_d;
    logic          op_q, op_d, err_q, err_d, spur_q, spur_d, rdv_q, rdv_d;
    logic [63:0]   base_q, base_d, seed_q, seed_d, chk_q, chk_d;
    logic [63:0]   rda_q, rda_d, rdd_q, rdd_d;
    logic [31:0]   num_q, num_d, idx_q, idx_d, idx_inc;
    logic [OW-1:0] outst_q, outst_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          accept, acked, resp_ok;

    assign busy              = state_q inside {ISSUE, WAIT_ACK, DRAIN};
    assign done              = state_q == DONE || state_q == ERR;
    assign error             = err_q;
    assign spurious          = spur_q;
    assign checksum          = chk_q;
    assign mem_req_valid     = state_q == ISSUE && (op_q || outst_q < OW'(MAX_OUTSTANDING));
    assign mem_req_addr      = mem_req_valid ? base_q + {29'd0, idx_q, 3'd0} : '0;
    assign mem_req_type      = mem_req_valid && op_q;
    assign mem_req_source_id = mem_req_valid ? SOURCE_ID : '0;
    assign mem_req_data      = (mem_req_valid && op_q) ? seed_q + {32'd0, idx_q} : '0;
    assign rd_valid          = rdv_q;
    assign rd_addr           = rda_q;
    assign rd_data           = rdd_q;

    always_comb begin
        accept  = state_q == IDLE && start && mem_init_done;
        acked   = state_q == WAIT_ACK && mem_req_ready;
        resp_ok = mem_resp_valid && !op_q && busy && outst_q != '0;
        idx_inc = idx_q + 32'd1;
        op_d    = accept ? op : op_q;
        base_d  = accept ? base_addr : base_q;
        num_d   = accept ? num_words : num_q;
        seed_d  = accept ? wr_seed : seed_q;
        idx_d   = accept ? '0 : acked ? idx_inc : idx_q;
        // an acceptance and a response in the same cycle cancel out
        outst_d = accept ? '0 : outst_q + OW'(acked && !op_q) - OW'(resp_ok);
        timer_d = accept ? '0 : state_q != DRAIN ? timer_q : resp_ok ? '0 : timer_q + TW'(1);
        chk_d   = accept ? '0 : resp_ok ? chk_q ^ mem_resp_data : chk_q;
        spur_d  = !accept && (spur_q || (mem_resp_valid && !resp_ok));
        rdv_d   = resp_ok;
        rda_d   = resp_ok ? mem_resp_addr : rda_q;
        rdd_d   = resp_ok ? mem_resp_data : rdd_q;
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept) state_d = num_words == 32'd0 ? DONE : ISSUE;
            ISSUE:    if (mem_req_valid) state_d = WAIT_ACK;
            WAIT_ACK: state_d = !mem_req_ready ? ISSUE : idx_inc < num_q ? ISSUE : op_q ? DONE : DRAIN;
            DRAIN:    state_d = outst_d == '0 ? DONE : timer_d == TW'(TIMEOUT_CYCLES) ? ERR : DRAIN;
            default:  state_d = IDLE;
        endcase
        err_d = !accept && (err_q || state_d == ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            base_q  <= '0;
            num_q   <= '0;
            seed_q  <= '0;
            idx_q   <= '0;
            outst_q <= '0;
            timer_q <= '0;
            chk_q   <= '0;
            err_q   <= 1'b0;
            spur_q  <= 1'b0;
            rdv_q   <= 1'b0;
            rda_q   <= '0;
            rdd_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            base_q  <= base_d;
            num_q   <= num_d;
            seed_q  <= seed_d;
            idx_q   <= idx_d;
            outst_q <= outst_d;
            timer_q <= timer_d;
            chk_q   <= chk_d;
            err_q   <= err_d;
            spur_q  <= spur_d;
            rdv_q   <= rdv_d;
            rda_q   <= rda_d;
            rdd_q   <= rdd_d;
        end
    end
endmodule

// File: tb/tb_mem_stream_initiator.sv
// tb_mem_stream_initiator: memory-port model with fixed read latency plus a scoreboard
// of requests, read returns and done pulses, checked by one task per scenario.
module tb_mem_stream_initiator;
    localparam int LAT = 10;

    typedef struct { int due; logic [63:0] addr; logic [63:0] data; bit spur; } resp_t;
    typedef struct { logic [63:0] addr; logic typ; logic [63:0] data; logic [31:0] sid; int cyc; } req_t;
    typedef struct { logic [63:0] addr; logic [63:0] data; } rd_t;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, op = 1'b0, mem_init_done = 1'b0;
    logic [63:0] base_addr = '0, wr_seed = '0;
    logic [31:0] num_words = '0;
    logic        busy, done, error, spurious, mem_req_valid, mem_req_type, rd_valid;
    logic [63:0] checksum, mem_req_addr, mem_req_data, rd_addr, rd_data;
    logic [31:0] mem_req_source_id;
    logic        mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_addr = '0, mem_resp_data = '0;

    resp_t pend[$];
    req_t  req_log[$];
    rd_t   exp_q[$], got_q[$];
    int    cyc = 0, inflight = 0, max_inflight = 0, done_cnt = 0, done_cyc = 0, ack_cyc = 0;
    int    nack_seen = 0, inject_seen = 0, nack_n = 0, inject_n = 0;
    logic  done_err = 1'b0, prev_valid = 1'b0, prev_type = 1'b0, resp_en = 1'b1;
    logic [63:0] prev_addr = '0, inject_addr = '0, inject_data = '0;
    int    checks = 0, failures = 0;

    mem_stream_initiator #(.MAX_OUTSTANDING(2), .SOURCE_ID(32'hABCD0001), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .base_addr(base_addr),
        .num_words(num_words), .wr_seed(wr_seed), .busy(busy), .done(done), .error(error),
        .checksum(checksum), .spurious(spurious), .mem_init_done(mem_init_done),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_type(mem_req_type),
        .mem_req_source_id(mem_req_source_id), .mem_req_data(mem_req_data),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .mem_resp_addr(mem_resp_addr), .mem_resp_data(mem_resp_data),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [63:0] data_of(input logic [63:0] a);
        data_of = 64'h1 << a[4:3];
    endfunction

    // memory model: acks the cycle after a valid, answers reads LAT cycles after acceptance
    initial begin
        req_t  rq;
        rd_t   rr;
        resp_t rs;
        forever begin
            @(negedge clk);
            cyc++;
            mem_resp_valid = 1'b0;
            mem_req_ready = 1'b0;
            if (!rst_n) begin
                prev_valid = 1'b0;
                pend.delete();
                inflight = 0;
            end else begin
                if (mem_req_valid) begin
                    rq = '{mem_req_addr, mem_req_type, mem_req_data, mem_req_source_id, cyc};
                    req_log.push_back(rq);
                end
                if (rd_valid) begin
                    rr = '{rd_addr, rd_data};
                    got_q.push_back(rr);
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    done_err = error;
                end
                if (inject_seen != inject_n) begin
                    inject_seen = inject_n;
                    rs = '{cyc, inject_addr, inject_data, 1'b1};
                    pend.push_front(rs);
                end
                if (pend.size() > 0 && pend[0].due <= cyc) begin
                    rs = pend.pop_front();
                    mem_resp_valid = 1'b1;
                    mem_resp_addr = rs.addr;
                    mem_resp_data = rs.data;
                    if (!rs.spur) begin
                        rr = '{rs.addr, rs.data};
                        exp_q.push_back(rr);
                        inflight--;
                    end
                end
                if (prev_valid) begin
                    if (nack_seen < nack_n) nack_seen++;
                    else begin
                        mem_req_ready = 1'b1;
                        ack_cyc = cyc;
                        if (!prev_type) begin
                            inflight++;
                            if (resp_en) begin
                                rs = '{cyc + LAT, prev_addr, data_of(prev_addr), 1'b0};
                                pend.push_back(rs);
                            end
                        end
                    end
                end
                if (inflight > max_inflight) max_inflight = inflight;
                prev_valid = mem_req_valid;
                prev_type = mem_req_type;
                prev_addr = mem_req_addr;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic o, input logic [63:0] b, input logic [31:0] n,
                               input logic [63:0] s, output int sc);
        tick(1);
        sc = cyc;
        op = o; base_addr = b; num_words = n; wr_seed = s; start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, output bit ok);
        ok = done_cnt != d0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick(1);
            ok = done_cnt != d0;
        end
    endtask

    task automatic test_reset();
        int sc;
        tick(3);
        checks++;
        if ({busy, done, error, spurious, mem_req_valid, rd_valid, checksum} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", {busy, done, error, spurious, mem_req_valid, rd_valid, checksum});
        end
        rst_n = 1'b1;
        tick(2);
        pulse_start(1'b1, 64'h100, 32'd2, 64'd0, sc);
        tick(3);
        checks++;
        if (busy !== 1'b0 || req_log.size() != 0) begin
            failures++;
            $display("FAIL start_without_init: busy=%b reqs=%0d expected busy=0 reqs=0", busy, req_log.size());
        end
    endtask

    task automatic test_write();
        int r0, d0, sc, n;
        bit ok;
        r0 = req_log.size(); d0 = done_cnt;
        mem_init_done = 1'b1;
        pulse_start(1'b1, 64'h1000, 32'd3, 64'd5, sc);
        wait_done(d0, 50, ok);
        tick(3);
        n = req_log.size() - r0;
        checks++;
        if (!ok || n != 3) begin
            failures++;
            $display("FAIL write_count: done_seen=%b reqs=%0d expected done_seen=1 reqs=3", ok, n);
        end
        for (int i = 0; i < n && i < 3; i++) begin
            checks++;
            if ({req_log[r0+i].addr, req_log[r0+i].typ, req_log[r0+i].data, req_log[r0+i].sid} !==
                {64'h1000 + 64'(8*i), 1'b1, 64'd5 + 64'(i), 32'hABCD0001} || req_log[r0+i].cyc != sc + 1 + 2*i) begin
                failures++;
                $display("FAIL write_req[%0d]: got addr=%h type=%b data=%h sid=%h cyc=%0d expected addr=%h type=1 data=%h sid=abcd0001 cyc=%0d",
                         i, req_log[r0+i].addr, req_log[r0+i].typ, req_log[r0+i].data, req_log[r0+i].sid,
                         req_log[r0+i].cyc, 64'h1000 + 64'(8*i), 64'd5 + 64'(i), sc + 1 + 2*i);
            end
        end
        checks++;
        if (done_cnt - d0 != 1 || done_err !== 1'b0 || {busy, error} !== 2'b00) begin
            failures++;
            $display("FAIL write_done: pulses=%0d err_at_done=%b busy=%b error=%b expected 1 0 0 0", done_cnt - d0, done_err, busy, error);
        end
    endtask

    task automatic test_read();
        int e0, g0, d0, sc, n;
        bit ok;
        logic [63:0] exp_chk;
        e0 = exp_q.size(); g0 = got_q.size(); d0 = done_cnt;
        pulse_start(1'b0, 64'h3000, 32'd4, 64'd0, sc);
        wait_done(d0, 200, ok);
        tick(3);
        n = got_q.size() - g0;
        checks++;
        if (!ok || n != 4 || exp_q.size() - e0 != 4) begin
            failures++;
            $display("FAIL read_count: done_seen=%b rd_valid=%0d sent=%0d expected 1 4 4", ok, n, exp_q.size() - e0);
        end
        exp_chk = '0;
        for (int i = 0; i < n && e0 + i < exp_q.size(); i++) begin
            exp_chk ^= exp_q[e0+i].data;
            checks++;
            if ({got_q[g0+i].addr, got_q[g0+i].data} !== {exp_q[e0+i].addr, exp_q[e0+i].data}) begin
                failures++;
                $display("FAIL read_data[%0d]: got %h/%h expected %h/%h", i, got_q[g0+i].addr, got_q[g0+i].data,
                         exp_q[e0+i].addr, exp_q[e0+i].data);
            end
        end
        checks++;
        if (checksum !== exp_chk) begin
            failures++;
            $display("FAIL read_checksum: got %h expected %h", checksum, exp_chk);
        end
        checks++;
        if (max_inflight != 2) begin
            failures++;
            $display("FAIL read_inflight: got max %0d expected 2", max_inflight);
        end
        checks++;
        if (done_cnt - d0 != 1 || done_err !== 1'b0 || spurious !== 1'b0) begin
            failures++;
            $display("FAIL read_done: pulses=%0d err=%b spurious=%b expected 1 0 0", done_cnt - d0, done_err, spurious);
        end
        tick(5);
        checks++;
        if (checksum !== exp_chk) begin
            failures++;
            $display("FAIL checksum_hold: got %h expected %h", checksum, exp_chk);
        end
    endtask

    task automatic test_retry();
        int r0, d0, sc, n;
        bit ok;
        logic [63:0] ea;
        r0 = req_log.size(); d0 = done_cnt;
        nack_n = nack_n + 2;
        pulse_start(1'b1, 64'h2000, 32'd2, 64'h40, sc);
        wait_done(d0, 50, ok);
        tick(3);
        n = req_log.size() - r0;
        checks++;
        if (!ok || n != 4) begin
            failures++;
            $display("FAIL retry_count: done_seen=%b reqs=%0d expected 1 4", ok, n);
        end
        for (int i = 0; i < n && i < 4; i++) begin
            ea = (i == 3) ? 64'h2008 : 64'h2000;
            checks++;
            if ({req_log[r0+i].addr, req_log[r0+i].data} !== {ea, 64'h40 + 64'(i == 3)}) begin
                failures++;
                $display("FAIL retry_req[%0d]: got %h/%h expected %h/%h", i, req_log[r0+i].addr, req_log[r0+i].data, ea, 64'h40 + 64'(i == 3));
            end
        end
    endtask

    task automatic test_timeout();
        int d0, g0, sc;
        bit ok;
        d0 = done_cnt; g0 = got_q.size();
        resp_en = 1'b0;
        pulse_start(1'b0, 64'h4000, 32'd1, 64'd0, sc);
        wait_done(d0, 100, ok);
        tick(2);
        checks++;
        if (!ok || done_cyc - ack_cyc != 17) begin
            failures++;
            $display("FAIL timeout_cycles: done_seen=%b ack_to_err=%0d expected 1 17", ok, done_cyc - ack_cyc);
        end
        checks++;
        if (done_err !== 1'b1 || done_cnt - d0 != 1 || error !== 1'b1 || busy !== 1'b0 || got_q.size() != g0) begin
            failures++;
            $display("FAIL timeout_error: err_at_done=%b pulses=%0d error=%b busy=%b rd=%0d expected 1 1 1 0 0",
                     done_err, done_cnt - d0, error, busy, got_q.size() - g0);
        end
        checks++;
        if (checksum !== 64'd0) begin
            failures++;
            $display("FAIL start_clears_checksum: got %h expected 0", checksum);
        end
        resp_en = 1'b1;
    endtask

    task automatic test_spurious_zero();
        int r0, d0, g0, sc;
        bit ok;
        g0 = got_q.size();
        inject_addr = 64'h5000; inject_data = 64'h77;
        inject_n = inject_n + 1;
        tick(4);
        checks++;
        if (spurious !== 1'b1 || got_q.size() != g0 || error !== 1'b1) begin
            failures++;
            $display("FAIL idle_spurious: spurious=%b rd=%0d error=%b expected 1 0 1", spurious, got_q.size() - g0, error);
        end
        r0 = req_log.size(); d0 = done_cnt;
        pulse_start(1'b1, 64'h6000, 32'd0, 64'd0, sc);
        wait_done(d0, 20, ok);
        tick(3);
        checks++;
        if (!ok || done_cnt - d0 != 1 || req_log.size() != r0) begin
            failures++;
            $display("FAIL zero_words: done_seen=%b pulses=%0d reqs=%0d expected 1 1 0", ok, done_cnt - d0, req_log.size() - r0);
        end
        checks++;
        if ({spurious, error} !== 2'b00) begin
            failures++;
            $display("FAIL start_clears_sticky: spurious=%b error=%b expected 0 0", spurious, error);
        end
    endtask

    task automatic test_reset_mid();
        int sc;
        bit ok;
        pulse_start(1'b0, 64'h3000, 32'd4, 64'd0, sc);
        ok = inflight == 2;
        for (int i = 0; i < 30 && !ok; i++) begin
            tick(1);
            ok = inflight == 2;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL reset_mid_setup: inflight=%0d expected 2", inflight);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, error, spurious, mem_req_valid, rd_valid, mem_req_type, checksum, mem_req_addr,
             mem_req_data, mem_req_source_id, rd_addr, rd_data} !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs: busy=%b valid=%b rd_valid=%b addr=%h rd_addr=%h rd_data=%h expected all 0",
                     busy, mem_req_valid, rd_valid, mem_req_addr, rd_addr, rd_data);
        end
        tick(3);
        rst_n = 1'b1;
        tick(1);
        test_read();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_retry();
        test_timeout();
        test_spurious_zero();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by 200000 time units");
        $fatal(1, "watchdog");
    end
endmodule
